// File: rtl/wb_grf.sv
// Write-back stage general register file: decodes the W-stage instruction into a
// GRF write, holds the register array and serves two D-stage read ports with bypass.
module wb_grf #(
   parameter int NREG = 32,
   parameter int DW   = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [31:0]   instrW,
   input  logic          changeW,
   input  logic [DW-1:0] wdataW,
   input  logic [4:0]    ra1,
   input  logic [4:0]    ra2,
   output logic [DW-1:0] rd1,
   output logic [DW-1:0] rd2,
   output logic          weW,
   output logic [4:0]    waW,
   output logic [31:0]   wr_cnt
);

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_LUI     = 6'h0F;
   localparam logic [5:0] OP_LW      = 6'h23;

   localparam logic [5:0] FN_JALR    = 6'h09;
   localparam logic [5:0] FN_MOVZ    = 6'h0A;
   localparam logic [5:0] FN_ADDU    = 6'h21;
   localparam logic [5:0] FN_SUBU    = 6'h23;

   logic [5:0]    op;
   logic [5:0]    fn;
   logic [4:0]    rt_f;
   logic [4:0]    rd_f;
   logic          dec_we;
   logic [4:0]    dest;

   logic [DW-1:0] grf_q [NREG];
   logic [DW-1:0] grf_d [NREG];
   logic [31:0]   wr_cnt_q;
   logic [31:0]   wr_cnt_d;

   logic          unused_instr_bits;

   assign op   = instrW[31:26];
   assign fn   = instrW[5:0];
   assign rt_f = instrW[20:16];
   assign rd_f = instrW[15:11];
   assign unused_instr_bits = ^{instrW[25:21], instrW[10:6]};

   // changeW only matters for the conditional move; all other writers ignore it.
   always_comb begin
      dec_we = 1'b0;
      dest   = 5'd0;
      case (op)
         OP_SPECIAL: begin
            case (fn)
               FN_ADDU, FN_SUBU, FN_JALR: begin
                  dec_we = 1'b1;
                  dest   = rd_f;
               end
               FN_MOVZ: begin
                  dec_we = changeW;
                  dest   = rd_f;
               end
               default: begin
                  dec_we = 1'b0;
                  dest   = 5'd0;
               end
            endcase
         end
         OP_ORI, OP_LUI, OP_LW: begin
            dec_we = 1'b1;
            dest   = rt_f;
         end
         OP_JAL: begin
            dec_we = 1'b1;
            dest   = 5'd31;
         end
         default: begin
            dec_we = 1'b0;
            dest   = 5'd0;
         end
      endcase
   end

   assign weW = dec_we && (dest != 5'd0);
   assign waW = weW ? dest : 5'd0;

   always_comb begin
      grf_d = grf_q;
      if (weW) begin
         grf_d[waW] = wdataW;
      end
      wr_cnt_d = wr_cnt_q + {31'd0, weW};
   end

   // Reset wins over a coinciding write, so nothing commits while rst is high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            grf_q[i] <= '0;
         end
         wr_cnt_q <= 32'd0;
      end else begin
         grf_q    <= grf_d;
         wr_cnt_q <= wr_cnt_d;
      end
   end

   assign wr_cnt = wr_cnt_q;

   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (!rst) begin
         if (ra1 != 5'd0) begin
            rd1 = (weW && (waW == ra1)) ? wdataW : grf_q[ra1];
         end
         if (ra2 != 5'd0) begin
            rd2 = (weW && (waW == ra2)) ? wdataW : grf_q[ra2];
         end
      end
   end

endmodule

// File: tb/tb_wb_grf.sv
// Self-checking bench for wb_grf: directed scenarios plus randomized instruction
// streams compared against a behavioural register-file model.
module tb_wb_grf;

   logic        clk;
   logic        rst;
   logic [31:0] instrW;
   logic        changeW;
   logic [31:0] wdataW;
   logic [4:0]  ra1;
   logic [4:0]  ra2;
   logic [31:0] rd1;
   logic [31:0] rd2;
   logic        weW;
   logic [4:0]  waW;
   logic [31:0] wr_cnt;

   int          vectors;
   int          miscompares;

   logic [31:0] mgrf [32];
   logic [31:0] mcnt;

   wb_grf #(.NREG(32), .DW(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .instrW  (instrW),
      .changeW (changeW),
      .wdataW  (wdataW),
      .ra1     (ra1),
      .ra2     (ra2),
      .rd1     (rd1),
      .rd2     (rd2),
      .weW     (weW),
      .waW     (waW),
      .wr_cnt  (wr_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] r_type(input logic [5:0] fn, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   // Destination register the spec's decode table gives, or -1 when nothing is written.
   function automatic int m_dest(input logic [31:0] ins, input logic chg);
      int d;
      d = -1;
      if (ins[31:26] == 6'h00) begin
         if (ins[5:0] == 6'h21 || ins[5:0] == 6'h23 || ins[5:0] == 6'h09) d = int'(ins[15:11]);
         else if (ins[5:0] == 6'h0A && chg) d = int'(ins[15:11]);
      end else if (ins[31:26] == 6'h0D || ins[31:26] == 6'h0F || ins[31:26] == 6'h23) begin
         d = int'(ins[20:16]);
      end else if (ins[31:26] == 6'h03) begin
         d = 31;
      end
      if (d == 0) d = -1;
      return d;
   endfunction

   function automatic logic [31:0] m_rd(input logic [4:0] a, input int d,
                                        input logic [31:0] wd, input logic r);
      if (r || a == 5'd0) return 32'd0;
      if (d == int'(a)) return wd;
      return mgrf[a];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) mgrf[i] = 32'd0;
      mcnt = 32'd0;
   endtask

   task automatic model_commit(input logic [31:0] ins, input logic chg, input logic [31:0] wd);
      int d;
      d = m_dest(ins, chg);
      if (!rst && d > 0) begin
         mgrf[d] = wd;
         mcnt    = mcnt + 32'd1;
      end
   endtask

   task automatic drive(input logic [31:0] ins, input logic chg, input logic [31:0] wd,
                        input logic [4:0] a1, input logic [4:0] a2);
      @(negedge clk);
      instrW  = ins;
      changeW = chg;
      wdataW  = wd;
      ra1     = a1;
      ra2     = a2;
      #1;
   endtask

   task automatic tick();
      model_commit(instrW, changeW, wdataW);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      instrW = 32'd0; changeW = 1'b0; wdataW = 32'd0; ra1 = 5'd0; ra2 = 5'd0;
      rst = 1'b0;
      #3 rst = 1'b1;
      model_clear();
      drive(i_type(6'h0D, 5'd0, 5'd3, 16'h55AA), 1'b0, 32'h55AA, 5'd3, 5'd3);
      vectors++;
      if (rd1 !== 32'd0 || rd2 !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_rd rd1=%h rd2=%h required 0", rd1, rd2);
      end
      vectors++;
      if (weW !== 1'b1 || waW !== 5'd3) begin
         miscompares++;
         $display("[TB] FAIL reset_decode weW=%b waW=%0d required 1/3", weW, waW);
      end
      tick();
      vectors++;
      if (wr_cnt !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_cnt wr_cnt=%h required 0", wr_cnt);
      end
      drive(32'd0, 1'b0, 32'd0, 5'd3, 5'd0);
      rst = 1'b0;
      #1;
      vectors++;
      if (rd1 !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_blocked_write rd1=%h required 0", rd1);
      end
   endtask

   task automatic test_bypass_ori();
      drive(i_type(6'h0D, 5'd0, 5'd5, 16'h1234), 1'b0, 32'h1234, 5'd5, 5'd0);
      vectors++;
      if (rd1 !== 32'h1234 || weW !== 1'b1 || waW !== 5'd5) begin
         miscompares++;
         $display("[TB] FAIL ori_bypass rd1=%h weW=%b waW=%0d required 1234/1/5", rd1, weW, waW);
      end
      tick();
      drive(32'd0, 1'b0, 32'hFFFF_0000, 5'd5, 5'd5);
      vectors++;
      if (rd1 !== 32'h1234 || rd2 !== 32'h1234 || weW !== 1'b0 || waW !== 5'd0) begin
         miscompares++;
         $display("[TB] FAIL ori_stored rd1=%h rd2=%h weW=%b required 1234/1234/0", rd1, rd2, weW);
      end
      vectors++;
      if (wr_cnt !== mcnt) begin
         miscompares++;
         $display("[TB] FAIL ori_cnt wr_cnt=%h required %h", wr_cnt, mcnt);
      end
   endtask

   task automatic test_jal_lw_zero();
      drive({6'h03, 26'h0000C02}, 1'b0, 32'h3008, 5'd0, 5'd31);
      tick();
      drive(32'd0, 1'b0, 32'd0, 5'd31, 5'd0);
      vectors++;
      if (rd1 !== 32'h3008) begin
         miscompares++;
         $display("[TB] FAIL jal_ra rd1=%h required 3008", rd1);
      end
      drive(i_type(6'h23, 5'd5, 5'd0, 16'h0004), 1'b0, 32'hFFFF, 5'd0, 5'd0);
      vectors++;
      if (weW !== 1'b0 || waW !== 5'd0 || rd1 !== 32'd0 || rd2 !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL lw_zero weW=%b waW=%0d rd1=%h rd2=%h required 0", weW, waW, rd1, rd2);
      end
      tick();
      vectors++;
      if (wr_cnt !== mcnt) begin
         miscompares++;
         $display("[TB] FAIL lw_zero_cnt wr_cnt=%h required %h", wr_cnt, mcnt);
      end
   endtask

   task automatic test_movz_cond();
      drive(r_type(6'h0A, 5'd1, 5'd2, 5'd7), 1'b0, 32'hAA, 5'd7, 5'd0);
      vectors++;
      if (weW !== 1'b0 || rd1 !== mgrf[7]) begin
         miscompares++;
         $display("[TB] FAIL movz_off weW=%b rd1=%h required 0/%h", weW, rd1, mgrf[7]);
      end
      tick();
      drive(r_type(6'h0A, 5'd1, 5'd2, 5'd7), 1'b1, 32'hAA, 5'd7, 5'd7);
      vectors++;
      if (weW !== 1'b1 || waW !== 5'd7 || rd2 !== 32'hAA) begin
         miscompares++;
         $display("[TB] FAIL movz_on weW=%b waW=%0d rd2=%h required 1/7/aa", weW, waW, rd2);
      end
      tick();
      drive(r_type(6'h21, 5'd1, 5'd2, 5'd8), 1'b0, 32'h88, 5'd7, 5'd8);
      vectors++;
      if (weW !== 1'b1 || rd1 !== 32'hAA || rd2 !== 32'h88) begin
         miscompares++;
         $display("[TB] FAIL addu_flag weW=%b rd1=%h rd2=%h required 1/aa/88", weW, rd1, rd2);
      end
      tick();
      vectors++;
      if (wr_cnt !== mcnt) begin
         miscompares++;
         $display("[TB] FAIL movz_cnt wr_cnt=%h required %h", wr_cnt, mcnt);
      end
   endtask

   task automatic test_nowrite();
      logic [31:0] list [4];
      list[0] = i_type(6'h2B, 5'd0, 5'd5, 16'h0010);
      list[1] = i_type(6'h04, 5'd5, 5'd7, 16'h0002);
      list[2] = {6'h02, 26'h0000C00};
      list[3] = r_type(6'h08, 5'd31, 5'd0, 5'd5);
      for (int i = 0; i < 4; i++) begin
         drive(list[i], 1'b1, 32'hDEAD, 5'd5, 5'd7);
         vectors++;
         if (weW !== 1'b0 || waW !== 5'd0 || rd1 !== mgrf[5] || rd2 !== mgrf[7]) begin
            miscompares++;
            $display("[TB] FAIL nowrite_%0d weW=%b waW=%0d rd1=%h rd2=%h", i, weW, waW, rd1, rd2);
         end
         tick();
      end
      vectors++;
      if (wr_cnt !== mcnt) begin
         miscompares++;
         $display("[TB] FAIL nowrite_cnt wr_cnt=%h required %h", wr_cnt, mcnt);
      end
   endtask

   task automatic test_wrap_dual_bypass();
      drive(r_type(6'h23, 5'd1, 5'd2, 5'd9), 1'b0, 32'hCAFE_F00D, 5'd9, 5'd9);
      force dut.wr_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.wr_cnt_q;
      #1;
      mcnt = 32'hFFFF_FFFF;
      vectors++;
      if (rd1 !== 32'hCAFE_F00D || rd2 !== 32'hCAFE_F00D || waW !== 5'd9) begin
         miscompares++;
         $display("[TB] FAIL dual_bypass rd1=%h rd2=%h waW=%0d required cafef00d x2 /9", rd1, rd2, waW);
      end
      tick();
      vectors++;
      if (wr_cnt !== 32'd0 || wr_cnt !== mcnt) begin
         miscompares++;
         $display("[TB] FAIL cnt_wrap wr_cnt=%h required 0", wr_cnt);
      end
   endtask

   task automatic test_random();
      logic [31:0] ins;
      logic        chg;
      logic [31:0] wd;
      logic [4:0]  a1;
      logic [4:0]  a2;
      logic [5:0]  fns [5];
      logic [5:0]  ops [7];
      int          d;
      fns[0] = 6'h21; fns[1] = 6'h23; fns[2] = 6'h09; fns[3] = 6'h0A; fns[4] = 6'h08;
      ops[0] = 6'h0D; ops[1] = 6'h0F; ops[2] = 6'h23; ops[3] = 6'h03;
      ops[4] = 6'h2B; ops[5] = 6'h04; ops[6] = 6'h02;
      for (int n = 0; n < 300; n++) begin
         ins = $urandom;
         case ($urandom_range(0, 3))
            0: ins = r_type(fns[$urandom_range(0, 4)], 5'($urandom_range(0, 31)),
                            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            1: ins = {ops[$urandom_range(0, 6)], 5'($urandom_range(0, 31)),
                      5'($urandom_range(0, 7)), 16'($urandom)};
            2: ins = {6'h00, ins[25:0]};
            default: ;
         endcase
         if ($urandom_range(0, 15) == 0) ins = 32'd0;
         chg = 1'($urandom);
         wd  = $urandom;
         a1  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
         a2  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
         drive(ins, chg, wd, a1, a2);
         d = m_dest(ins, chg);
         vectors++;
         if (weW !== (d > 0) || waW !== ((d > 0) ? 5'(d) : 5'd0)) begin
            miscompares++;
            $display("[TB] FAIL rand_decode ins=%h chg=%b weW=%b waW=%0d required dest %0d",
                     ins, chg, weW, waW, d);
         end
         vectors++;
         if (rd1 !== m_rd(a1, d, wd, rst) || rd2 !== m_rd(a2, d, wd, rst)) begin
            miscompares++;
            $display("[TB] FAIL rand_read ra1=%0d rd1=%h req %h ra2=%0d rd2=%h req %h",
                     a1, rd1, m_rd(a1, d, wd, rst), a2, rd2, m_rd(a2, d, wd, rst));
         end
         tick();
         vectors++;
         if (wr_cnt !== mcnt) begin
            miscompares++;
            $display("[TB] FAIL rand_cnt wr_cnt=%h required %h", wr_cnt, mcnt);
         end
      end
   endtask

   task automatic test_reset_midstream();
      drive(i_type(6'h0F, 5'd0, 5'd4, 16'hBEEF), 1'b0, 32'hBEEF_0000, 5'd4, 5'd31);
      #2 rst = 1'b1;
      model_clear();
      #1;
      vectors++;
      if (rd1 !== 32'd0 || rd2 !== 32'd0 || wr_cnt !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL midreset rd1=%h rd2=%h wr_cnt=%h required 0", rd1, rd2, wr_cnt);
      end
      tick();
      drive(32'd0, 1'b0, 32'd0, 5'd4, 5'd31);
      rst = 1'b0;
      #1;
      vectors++;
      if (rd1 !== 32'd0 || rd2 !== 32'd0 || wr_cnt !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL midreset_after rd1=%h rd2=%h wr_cnt=%h required 0", rd1, rd2, wr_cnt);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_bypass_ori();
      test_jal_lw_zero();
      test_movz_cond();
      test_nowrite();
      test_wrap_dual_bypass();
      test_random();
      test_reset_midstream();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
